// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared CPU constants and next-PC priority encoding for the fetch stage
package fetch_stage_pkg;

    localparam logic [31:0] PC_RESET   = 32'h0000_3000;
    localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;
    localparam logic [4:0]  EXC_ADEL   = 5'd4;
    localparam logic [4:0]  EXC_NONE   = 5'd0;
    localparam logic [31:0] NOP        = 32'h0000_0000;

    typedef enum logic [2:0] {
        SEL_RESET,
        SEL_EXC,
        SEL_ERET,
        SEL_HOLD,
        SEL_REDIRECT,
        SEL_SEQ
    } npc_sel_e;

    // Exceptions and eret must beat stall so a stalled pipe can still be flushed.
    function automatic npc_sel_e npc_select(input logic clr, input logic int_req,
                                            input logic eret, input logic stall,
                                            input logic redirect);
        if (clr)           return SEL_RESET;
        else if (int_req)  return SEL_EXC;
        else if (eret)     return SEL_ERET;
        else if (stall)    return SEL_HOLD;
        else if (redirect) return SEL_REDIRECT;
        else               return SEL_SEQ;
    endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// rtl/fetch_pc_reg.sv - fetch PC register with prioritised next-PC selection
module fetch_pc_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] PC_RESET   = fetch_stage_pkg::PC_RESET,
    parameter logic [31:0] EXC_VECTOR = fetch_stage_pkg::EXC_VECTOR
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] npc,
    input  logic        eret,
    input  logic [31:0] epc,
    input  logic        int_req,
    output logic [31:0] pc
);

    always_ff @(posedge clk) begin
        case (npc_select(clr, int_req, eret, stall, redirect))
            SEL_RESET:    pc <= PC_RESET;
            SEL_EXC:      pc <= EXC_VECTOR;
            SEL_ERET:     pc <= epc;
            SEL_HOLD:     pc <= pc;
            SEL_REDIRECT: pc <= npc;
            default:      pc <= pc + 32'd4;
        endcase
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch with ROM and F/D register; FETCH_ADEL_CHECK_EN enables the AdEL fetch-fault check
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] PC_RESET   = fetch_stage_pkg::PC_RESET,
    parameter logic [31:0] EXC_VECTOR = fetch_stage_pkg::EXC_VECTOR,
    parameter int          IM_WORDS   = 4096
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        stall,
    input  logic        redirect_D,
    input  logic [31:0] NPCout,
    input  logic        eret,
    input  logic [31:0] epc,
    input  logic        int_req,
    output logic [31:0] pc_F,
    output logic [31:0] IR_D,
    output logic [31:0] pc4_D,
    output logic [31:0] pc_D,
    output logic [4:0]  exc_D
);

    localparam int AW = (IM_WORDS > 1) ? $clog2(IM_WORDS) : 1;

    logic [31:0]   im [IM_WORDS];
    logic [AW-1:0] rom_idx;
    logic [31:0]   ir_F;
    logic          fault;

    // Out-of-range PCs alias back into the ROM rather than reading past it.
    assign rom_idx = AW'(((pc_F - PC_RESET) >> 2) % IM_WORDS);
    assign ir_F    = im[rom_idx];

`ifdef FETCH_ADEL_CHECK_EN
    logic [31:0] pc_off;
    assign pc_off = pc_F - PC_RESET;
    assign fault  = (pc_F[1:0] != 2'b00) || ({1'b0, pc_off} >= 33'(4 * IM_WORDS));
`else
    assign fault  = 1'b0;
`endif

    fetch_pc_reg #(
        .PC_RESET   (PC_RESET),
        .EXC_VECTOR (EXC_VECTOR)
    ) u_pc_reg (
        .clk      (clk),
        .clr      (clr),
        .stall    (stall),
        .redirect (redirect_D),
        .npc      (NPCout),
        .eret     (eret),
        .epc      (epc),
        .int_req  (int_req),
        .pc       (pc_F)
    );

    // A redirect still loads the current word: it is the branch delay slot.
    always_ff @(posedge clk) begin
        if (clr || int_req || eret) begin
            IR_D  <= NOP;
            pc4_D <= 32'd0;
            pc_D  <= 32'd0;
            exc_D <= EXC_NONE;
        end else if (!stall) begin
            IR_D  <= fault ? NOP : ir_F;
            pc4_D <= pc_F + 32'd4;
            pc_D  <= pc_F;
            exc_D <= fault ? EXC_ADEL : EXC_NONE;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage: directed scenarios then constrained-random traffic
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam logic [31:0] EXC_PC = 32'h0000_4180;
    localparam int          WORDS  = 4096;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_D = 1'b0;
    logic [31:0] NPCout = 32'd0;
    logic        eret = 1'b0;
    logic [31:0] epc = 32'd0;
    logic        int_req = 1'b0;
    logic [31:0] pc_F;
    logic [31:0] IR_D;
    logic [31:0] pc4_D;
    logic [31:0] pc_D;
    logic [4:0]  exc_D;

    typedef struct {
        string       tag;
        logic [31:0] pc_f;
        logic [31:0] ir;
        logic [31:0] pc4;
        logic [31:0] pcd;
        logic [4:0]  exc;
    } exp_t;

    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [31:0] m_pc, m_ir, m_pc4, m_pcd;
    logic [4:0]  m_exc;

    fetch_stage #(
        .PC_RESET   (RST_PC),
        .EXC_VECTOR (EXC_PC),
        .IM_WORDS   (WORDS)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .stall      (stall),
        .redirect_D (redirect_D),
        .NPCout     (NPCout),
        .eret       (eret),
        .epc        (epc),
        .int_req    (int_req),
        .pc_F       (pc_F),
        .IR_D       (IR_D),
        .pc4_D      (pc4_D),
        .pc_D       (pc_D),
        .exc_D      (exc_D)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input int idx);
        return 32'hA500_0000 ^ (32'(idx) * 32'h0001_0203) ^ 32'h0000_1357;
    endfunction

    function automatic logic [31:0] rom_at(input logic [31:0] pc);
        logic [31:0] off;
        off = (pc - RST_PC) >> 2;
        return rom_word(int'(off % WORDS));
    endfunction

    function automatic logic pc_faults(input logic [31:0] pc);
`ifdef FETCH_ADEL_CHECK_EN
        return (pc[1:0] != 2'b00) || (pc < RST_PC) || ({32'd0, pc} >= {32'd0, RST_PC} + 64'(4 * WORDS));
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input logic c, input logic s, input logic r,
                        input logic [31:0] n, input logic e, input logic [31:0] ep,
                        input logic ir);
        exp_t x;
        exp_t got;
        clr = c; stall = s; redirect_D = r; NPCout = n; eret = e; epc = ep; int_req = ir;
        if (c || ir || e) begin
            m_ir = 32'd0; m_pc4 = 32'd0; m_pcd = 32'd0; m_exc = 5'd0;
            m_pc = c ? RST_PC : (ir ? EXC_PC : ep);
        end else if (!s) begin
            m_ir  = pc_faults(m_pc) ? 32'd0 : rom_at(m_pc);
            m_exc = pc_faults(m_pc) ? 5'd4 : 5'd0;
            m_pcd = m_pc;
            m_pc4 = m_pc + 32'd4;
            m_pc  = r ? n : m_pc + 32'd4;
        end
        x.tag = tag; x.pc_f = m_pc; x.ir = m_ir; x.pc4 = m_pc4; x.pcd = m_pcd; x.exc = m_exc;
        sbq.push_back(x);
        @(posedge clk);
        #1;
        got = sbq.pop_front();
        check({got.tag, ".pc_F"},  pc_F,           got.pc_f);
        check({got.tag, ".IR_D"},  IR_D,           got.ir);
        check({got.tag, ".pc4_D"}, pc4_D,          got.pc4);
        check({got.tag, ".pc_D"},  pc_D,           got.pcd);
        check({got.tag, ".exc_D"}, {27'd0, exc_D}, {27'd0, got.exc});
    endtask

    initial begin
        #1;
        for (int i = 0; i < WORDS; i++) dut.im[i] = rom_word(i);

        step("reset", 1, 0, 0, 32'd0, 0, 32'd0, 0);
        check("reset_pc_abs", pc_F, 32'h0000_3000);
        for (int i = 0; i < 3; i++) step("free", 0, 0, 0, 32'd0, 0, 32'd0, 0);
        check("free_pc_abs", pc_F, 32'h0000_300C);

        step("branch", 0, 0, 1, 32'h0000_3040, 0, 32'd0, 0);
        check("delay_slot_abs", IR_D, rom_word(3));
        step("after_branch", 0, 0, 0, 32'd0, 0, 32'd0, 0);

        step("to_3010", 0, 0, 1, 32'h0000_3010, 0, 32'd0, 0);
        step("stall1", 0, 1, 1, 32'h0000_3100, 0, 32'd0, 0);
        step("stall2", 0, 1, 0, 32'd0, 0, 32'd0, 0);
        step("resume", 0, 0, 0, 32'd0, 0, 32'd0, 0);
        check("resume_pc_abs", pc_F, 32'h0000_3014);

        step("priority", 0, 1, 1, 32'h0000_3200, 1, 32'h0000_3300, 1);
        check("priority_pc_abs", pc_F, 32'h0000_4180);
        step("eret", 0, 0, 0, 32'd0, 1, 32'h0000_3020, 0);
        step("eret_stalled", 0, 1, 0, 32'd0, 1, 32'h0000_3024, 0);

        step("to_3002", 0, 0, 1, 32'h0000_3002, 0, 32'd0, 0);
        step("fault", 0, 0, 0, 32'd0, 0, 32'd0, 0);
`ifdef FETCH_ADEL_CHECK_EN
        check("fault_exc_abs", {27'd0, exc_D}, 32'd4);
`else
        check("fault_exc_abs", {27'd0, exc_D}, 32'd0);
`endif

        step("pre_clr_stall", 0, 1, 0, 32'd0, 0, 32'd0, 0);
        step("clr_mid_stall", 1, 1, 1, 32'h0000_3500, 0, 32'd0, 0);
        step("to_top", 0, 0, 1, 32'hFFFF_FFFC, 0, 32'd0, 0);
        step("wrap", 0, 0, 0, 32'd0, 0, 32'd0, 0);
        check("wrap_pc_abs", pc_F, 32'h0000_0000);
        step("clr_mid_redirect", 1, 0, 1, 32'h0000_3600, 0, 32'd0, 0);

        for (int k = 0; k < 120; k++) begin
            logic [31:0] n, ep;
            n  = RST_PC + 32'($urandom_range(0, WORDS + 8)) * 4 + (($urandom % 8 == 0) ? 32'd2 : 32'd0);
            ep = RST_PC + 32'($urandom_range(0, WORDS - 1)) * 4;
            step("rand", ($urandom % 25) == 0, ($urandom % 4) == 0, ($urandom % 4) == 0, n,
                 ($urandom % 12) == 0, ep, ($urandom % 15) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter PC_RESET, default 32'h0000_3000, meaning PC value loaded on reset.
REQ-002 SHALL have parameter EXC_VECTOR, default 32'h0000_4180, meaning exception handler entry PC.
REQ-003 SHALL have parameter IM_WORDS, default 4096, meaning instruction ROM depth in words, initialised from hex file code.txt.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 clr  input  1  synchronous, active-high reset.
REQ-006 stall  input  1  hazard stall from the decode stage; holds PC and F/D register.
REQ-007 redirect_D  input  1  decode stage takes a branch or jump this cycle.
REQ-008 NPCout  input  32  branch/jump target computed in decode.
REQ-009 eret  input  1  eret resolved in decode; return to epc.
REQ-010 epc  input  32  exception return address.
REQ-011 int_req  input  1  exception or interrupt accepted; vector to EXC_VECTOR.
REQ-012 pc_F  output  32  current fetch PC.
REQ-013 IR_D  output  32  instruction latched for decode.
REQ-014 pc4_D  output  32  PC+4 of the latched instruction.
REQ-015 pc_D  output  32  PC of the latched instruction, used for EPC and delay-slot tracking.
REQ-016 exc_D  output  5  exception code travelling with IR_D; 0 means none.

Function
REQ-017 SHALL read IR combinationally from ROM word index (pc_F - PC_RESET)[13:2].
REQ-018 SHALL load IR_D, pc4_D, pc_D and exc_D one cycle after fetch, giving F-to-D latency 1.
REQ-019 SHALL select the next pc_F by priority: clr, then int_req (EXC_VECTOR), then eret (epc), then stall (hold), then redirect_D (NPCout), otherwise pc_F+4.
REQ-020 SHALL flush on int_req or eret: IR_D=0 (nop), pc4_D=0, pc_D=0, exc_D=0, taking precedence over an active stall.
REQ-021 SHALL hold pc_F and all F/D outputs unchanged while stall=1 with no int_req or eret.
REQ-022 SHALL keep the delay-slot instruction on redirect_D: the F/D register loads the currently fetched word and pc_F takes NPCout.
REQ-023 SHALL ignore redirect_D while stall=1, because decode re-issues the redirect after the stall clears.
REQ-024 SHALL wrap pc_F+4 modulo 2^32 with no saturation.
REQ-025 SHALL wrap the ROM index modulo IM_WORDS for PCs outside the ROM when the alignment/range check is compiled out.

Reset
REQ-026 SHALL, on clr, set pc_F=PC_RESET, IR_D=0, pc4_D=0, pc_D=0 and exc_D=0 on the next rising edge, whatever the other inputs are.
REQ-027 SHALL apply clr asserted mid-stall or mid-redirect, discarding the pending action.

Configuration
REQ-028 SHALL compile the fetch address check in only when FETCH_ADEL_CHECK_EN is defined.
REQ-029 SHALL, with FETCH_ADEL_CHECK_EN defined, treat pc_F[1:0]!=0 or pc_F outside [PC_RESET, PC_RESET+4*IM_WORDS) as a fetch fault: IR_D=0 and exc_D=4 (AdEL), with pc_D = the faulting pc_F.
REQ-030 SHALL, without FETCH_ADEL_CHECK_EN, tie exc_D to 0 and pass the ROM word through unchanged.

Structure
REQ-031 SHALL take PC_RESET, EXC_VECTOR, EXC_ADEL=5'd4 and NOP=32'h0 from the shared CPU constants package.
REQ-032 SHALL be built from one sub-module, fetch_pc_reg (PC register with priority next-PC mux); the ROM and F/D register stay in fetch_stage.

Verification
REQ-033 Reset: clr=1 for 1 cycle, then 3 free cycles -> pc_F reads 0x3000, 0x3004, 0x3008; IR_D equals ROM[0] after the first post-reset edge.
REQ-034 Branch: redirect_D=1 with NPCout=0x3040 while pc_F=0x300C -> next pc_F=0x3040; IR_D equals ROM[3] (delay slot) with pc_D=0x300C.
REQ-035 Stall: stall=1 for 2 cycles at pc_F=0x3010 -> pc_F, IR_D and pc_D are unchanged for both cycles, and fetch resumes at 0x3014.
REQ-036 Priority: int_req=1, eret=1, stall=1 and redirect_D=1 together -> pc_F=0x4180 and IR_D=0.
REQ-037 eret: eret=1 with epc=0x3020 -> pc_F=0x3020 next cycle and the F/D register is flushed to a nop.
REQ-038 Fetch fault (FETCH_ADEL_CHECK_EN defined): redirect to NPCout=0x3002 -> next IR_D=0, exc_D=4, pc_D=0x3002; same stimulus with the macro undefined -> exc_D=0.
